// File: rtl/round_timer_if.sv
// round_timer_if: control pulses in, registered countdown status out; master = round controller, slave = timer.
// No backpressure: the timer consumes every control pulse on the edge it is presented.
interface round_timer_if #(
    parameter int TIMER_W = 5
);
    logic [1:0]         mode;
    logic               start;
    logic               pause;
    logic               clear;
    logic               tick;
`ifdef ROUND_TIMER_BONUS_EN
    logic               bonus;
`endif
    logic [TIMER_W-1:0] timer;
    logic               running;
    logic               expired;

`ifdef ROUND_TIMER_BONUS_EN
    modport master (
        output mode, start, pause, clear, tick, bonus,
        input  timer, running, expired
    );
    modport slave (
        input  mode, start, pause, clear, tick, bonus,
        output timer, running, expired
    );
`else
    modport master (
        output mode, start, pause, clear, tick,
        input  timer, running, expired
    );
    modport slave (
        input  mode, start, pause, clear, tick,
        output timer, running, expired
    );
`endif
endinterface

// File: rtl/round_timer.sv
// round_timer: game-round countdown (IDLE/RUN/PAUSED/DONE), registered outputs, one-edge control latency.
// No backpressure: inputs act on their edge. Option macro ROUND_TIMER_BONUS_EN adds the bonus input.
module round_timer #(
    parameter int TIMER_W  = 5,
    parameter int PRE0     = 14,
    parameter int PRE1     = 10,
    parameter int PRE2     = 8,
    parameter int PRE3     = 6,
    parameter int IDLE_VAL = 10,
    parameter int BONUS    = 3
) (
    input  logic          clk,
    input  logic          rst,
    round_timer_if.slave  bus
);
    localparam int TMAX = (1 << TIMER_W) - 1;

    if (TIMER_W < 3 || TIMER_W > 16) begin : g_bad_width
        $error("round_timer: TIMER_W must be within 3..16");
    end
    if (PRE0 < 0 || PRE0 > TMAX || PRE1 < 0 || PRE1 > TMAX ||
        PRE2 < 0 || PRE2 > TMAX || PRE3 < 0 || PRE3 > TMAX) begin : g_bad_preload
        $error("round_timer: a preload does not fit in TIMER_W bits");
    end
    if (IDLE_VAL < 0 || IDLE_VAL > TMAX || BONUS < 0) begin : g_bad_misc
        $error("round_timer: IDLE_VAL or BONUS out of range");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [TIMER_W-1:0] PRE0_V = TIMER_W'(PRE0);
    localparam logic [TIMER_W-1:0] PRE1_V = TIMER_W'(PRE1);
    localparam logic [TIMER_W-1:0] PRE2_V = TIMER_W'(PRE2);
    localparam logic [TIMER_W-1:0] PRE3_V = TIMER_W'(PRE3);
    localparam logic [TIMER_W-1:0] IDLE_V = TIMER_W'(IDLE_VAL);

    logic [1:0]         state, state_nx;
    logic [1:0]         mode_q, mode_nx;
    logic [TIMER_W-1:0] timer_q, timer_nx;
    logic               expired_q, expired_nx;
    logic               dec;
    logic [TIMER_W-1:0] adj;

    function automatic logic [TIMER_W-1:0] preload(input logic [1:0] m);
        case (m)
            2'd0:    preload = PRE0_V;
            2'd1:    preload = PRE1_V;
            2'd2:    preload = PRE2_V;
            default: preload = PRE3_V;
        endcase
    endfunction

    // A coincident pause wins over tick, so only an unpaused RUN cycle counts down.
    assign dec = (state == S_RUN) && bus.tick && !bus.pause && (timer_q != '0);

`ifdef ROUND_TIMER_BONUS_EN
    localparam logic [TIMER_W-1:0] BONUS_V = (BONUS > TMAX) ? TIMER_W'(TMAX) : TIMER_W'(BONUS);
    logic [TIMER_W-1:0] add;
    logic [TIMER_W:0]   sum;

    // Sum is one bit wider so the saturation test sees the carry; timer >= 1 whenever dec is set.
    assign add = bus.bonus ? BONUS_V : '0;
    assign sum = {1'b0, timer_q} + {1'b0, add} - {{TIMER_W{1'b0}}, dec};
    assign adj = (sum > {1'b0, TIMER_W'(TMAX)}) ? TIMER_W'(TMAX) : sum[TIMER_W-1:0];
`else
    assign adj = timer_q - {{(TIMER_W-1){1'b0}}, dec};
`endif

    always_comb begin
        state_nx   = state;
        mode_nx    = mode_q;
        timer_nx   = timer_q;
        expired_nx = 1'b0;
        if (bus.clear) begin
            state_nx = S_IDLE;
            timer_nx = IDLE_V;
        end else if (bus.start) begin
            mode_nx  = bus.mode;
            timer_nx = preload(bus.mode);
            if (preload(bus.mode) == '0) begin
                state_nx   = S_DONE;
                expired_nx = 1'b1;
            end else if (bus.pause) begin
                state_nx = S_PAUSED;
            end else begin
                state_nx = S_RUN;
            end
        end else begin
            case (state)
                S_RUN: begin
                    timer_nx = adj;
                    if (bus.pause) begin
                        state_nx = S_PAUSED;
                    end else if (adj == '0) begin
                        state_nx   = S_DONE;
                        expired_nx = 1'b1;
                    end
                end
                S_PAUSED: begin
                    timer_nx = adj;
                    if (!bus.pause) begin
                        state_nx = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= 2'd0;
            timer_q   <= IDLE_V;
            expired_q <= 1'b0;
        end else begin
            state     <= state_nx;
            mode_q    <= mode_nx;
            timer_q   <= timer_nx;
            expired_q <= expired_nx;
        end
    end

    assign bus.timer   = timer_q;
    assign bus.running = (state == S_RUN);
    assign bus.expired = expired_q;
endmodule
